// File: rtl/cycle_term_ctrl.sv
// Bus-cycle terminator for the 68000 accelerator: per-channel wait-state DTACK,
// external DTACK merge, BERR on unterminated external cycles, safe clock-speed switching.
module cycle_term_ctrl #(
    parameter int NUM_CH      = 2,
    parameter int WS_WIDTH    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                         C14M,
    input  logic                         RESET,
    input  logic                         AS_CPU_n,
    input  logic [NUM_CH-1:0]            CH_SEL,
    input  logic [NUM_CH*WS_WIDTH-1:0]   CH_WS,
    input  logic                         DTACK_MB_n,
    input  logic                         M6800_DTACK_n,
    input  logic                         SW1,
    output logic                         DTACK_n,
    output logic                         BERR_n,
    output logic                         CLK_SEL,
    output logic [NUM_CH-1:0]            CH_ACK
);

    localparam int IW = (NUM_CH > 32'sd1) ? $clog2(NUM_CH) : 32'sd1;
    localparam int TW = $clog2(TIMEOUT + 32'sd1);
    localparam logic [TW-1:0]       T_LAST = TW'(TIMEOUT - 32'sd1);
    localparam logic [TW-1:0]       T_ONE  = TW'(1'b1);
    localparam logic [WS_WIDTH-1:0] W_ONE  = WS_WIDTH'(1'b1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_EXT  = 3'd2,
        S_ACK  = 3'd3,
        S_ERR  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    logic [SYNC_STAGES-1:0] as_sync_r;
    logic [SYNC_STAGES-1:0] sw_sync_r;
    logic                   as_s;
    logic                   sw_s;
    logic                   ext_ack_s;
    logic                   sel_any_s;
    logic [IW-1:0]          sel_idx_s;
    logic [WS_WIDTH-1:0]    sel_ws_s;

    state_t                 state_r,       state_nxt_s;
    logic [WS_WIDTH-1:0]    cnt_r,         cnt_nxt_s;
    logic [TW-1:0]          tcnt_r,        tcnt_nxt_s;
    logic [IW-1:0]          idx_r,         idx_nxt_s;
    logic                   dtack_int_n_r, dtack_int_n_nxt_s;
    logic                   berr_n_r,      berr_n_nxt_s;
    logic                   clk_sel_r,     clk_sel_nxt_s;
    logic [NUM_CH-1:0]      ch_ack_r,      ch_ack_nxt_s;

    function automatic logic [NUM_CH-1:0] onehot(input logic [IW-1:0] idx);
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) begin
            v[i] = (idx == IW'(i));
        end
        return v;
    endfunction

    // Synchronisers for the asynchronous address strobe and speed switch
    always_ff @(posedge C14M) begin
        if (RESET) begin
            as_sync_r <= {SYNC_STAGES{1'b1}};
            sw_sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            as_sync_r <= {as_sync_r[SYNC_STAGES-2:0], AS_CPU_n};
            sw_sync_r <= {sw_sync_r[SYNC_STAGES-2:0], SW1};
        end
    end

    assign as_s      = as_sync_r[SYNC_STAGES-1];
    assign sw_s      = sw_sync_r[SYNC_STAGES-1];
    assign ext_ack_s = ~(DTACK_MB_n & M6800_DTACK_n);
    assign sel_any_s = |CH_SEL;
    assign DTACK_n   = dtack_int_n_r & DTACK_MB_n & M6800_DTACK_n;
    assign BERR_n    = berr_n_r;
    assign CLK_SEL   = clk_sel_r;
    assign CH_ACK    = ch_ack_r;

    // Priority encoder: lowest selected channel and its wait-state count
    always_comb begin
        sel_idx_s = {IW{1'b0}};
        sel_ws_s  = {WS_WIDTH{1'b0}};
        for (int i = NUM_CH - 1; i >= 32'sd0; i--) begin
            sel_idx_s = CH_SEL[i] ? IW'(i) : sel_idx_s;
            sel_ws_s  = CH_SEL[i] ? CH_WS[i*WS_WIDTH +: WS_WIDTH] : sel_ws_s;
        end
    end

    // Next-state and next-output logic of the termination FSM
    always_comb begin
        state_nxt_s       = state_r;
        cnt_nxt_s         = cnt_r;
        tcnt_nxt_s        = tcnt_r;
        idx_nxt_s         = idx_r;
        dtack_int_n_nxt_s = dtack_int_n_r;
        berr_n_nxt_s      = berr_n_r;
        clk_sel_nxt_s     = clk_sel_r;
        ch_ack_nxt_s      = ch_ack_r;
        case (state_r)
            S_IDLE: begin
                if (!as_s) begin
                    if (sel_any_s) begin
                        state_nxt_s = S_WAIT;
                        cnt_nxt_s   = sel_ws_s;
                        idx_nxt_s   = sel_idx_s;
                    end else begin
                        state_nxt_s = S_EXT;
                        tcnt_nxt_s  = {TW{1'b0}};
                    end
                end else if (DTACK_n) begin
                    // Speed changes only while the bus is fully quiet
                    clk_sel_nxt_s = sw_s;
                end else begin
                    clk_sel_nxt_s = clk_sel_r;
                end
            end
            S_WAIT: begin
                if (as_s) begin
                    state_nxt_s = S_IDLE;
                end else if (cnt_r == {WS_WIDTH{1'b0}}) begin
                    state_nxt_s       = S_ACK;
                    dtack_int_n_nxt_s = 1'b0;
                    ch_ack_nxt_s      = onehot(idx_r);
                end else begin
                    cnt_nxt_s = cnt_r - W_ONE;
                end
            end
            S_ACK: begin
                if (as_s) begin
                    state_nxt_s       = S_IDLE;
                    dtack_int_n_nxt_s = 1'b1;
                    ch_ack_nxt_s      = {NUM_CH{1'b0}};
                end else begin
                    state_nxt_s = S_ACK;
                end
            end
            S_EXT: begin
                // External acknowledge outranks both abort and timeout
                if (ext_ack_s) begin
                    state_nxt_s = S_DONE;
                end else if (as_s) begin
                    state_nxt_s = S_IDLE;
                end else if (tcnt_r == T_LAST) begin
                    state_nxt_s  = S_ERR;
                    berr_n_nxt_s = 1'b0;
                end else begin
                    tcnt_nxt_s = tcnt_r + T_ONE;
                end
            end
            S_ERR: begin
                if (as_s) begin
                    state_nxt_s  = S_IDLE;
                    berr_n_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = S_ERR;
                end
            end
            S_DONE: begin
                if (as_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_DONE;
                end
            end
            default: begin
                state_nxt_s       = S_IDLE;
                dtack_int_n_nxt_s = 1'b1;
                berr_n_nxt_s      = 1'b1;
                ch_ack_nxt_s      = {NUM_CH{1'b0}};
            end
        endcase
    end

    // State, counter and registered output updates
    always_ff @(posedge C14M) begin
        if (RESET) begin
            state_r       <= S_IDLE;
            cnt_r         <= {WS_WIDTH{1'b0}};
            tcnt_r        <= {TW{1'b0}};
            idx_r         <= {IW{1'b0}};
            dtack_int_n_r <= 1'b1;
            berr_n_r      <= 1'b1;
            clk_sel_r     <= 1'b1;
            ch_ack_r      <= {NUM_CH{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            cnt_r         <= cnt_nxt_s;
            tcnt_r        <= tcnt_nxt_s;
            idx_r         <= idx_nxt_s;
            dtack_int_n_r <= dtack_int_n_nxt_s;
            berr_n_r      <= berr_n_nxt_s;
            clk_sel_r     <= clk_sel_nxt_s;
            ch_ack_r      <= ch_ack_nxt_s;
        end
    end

endmodule

// File: tb/tb_cycle_term_ctrl.sv
// Directed bench for cycle_term_ctrl: an elapsed-time model of each bus cycle is
// compared every clock, plus hand-computed expectations at key edges.
module tb_cycle_term_ctrl;

    localparam int NUM_CH      = 2;
    localparam int WS_WIDTH    = 4;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 255;

    logic       C14M          = 1'b0;
    logic       RESET         = 1'b1;
    logic       AS_CPU_n      = 1'b1;
    logic [1:0] CH_SEL        = 2'b00;
    logic [7:0] CH_WS         = 8'h00;
    logic       DTACK_MB_n    = 1'b1;
    logic       M6800_DTACK_n = 1'b1;
    logic       SW1           = 1'b1;
    logic       DTACK_n;
    logic       BERR_n;
    logic       CLK_SEL;
    logic [1:0] CH_ACK;

    int errors = 0;
    int checks = 0;

    cycle_term_ctrl #(
        .NUM_CH(NUM_CH), .WS_WIDTH(WS_WIDTH), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)
    ) dut (
        .C14M(C14M), .RESET(RESET), .AS_CPU_n(AS_CPU_n), .CH_SEL(CH_SEL), .CH_WS(CH_WS),
        .DTACK_MB_n(DTACK_MB_n), .M6800_DTACK_n(M6800_DTACK_n), .SW1(SW1),
        .DTACK_n(DTACK_n), .BERR_n(BERR_n), .CLK_SEL(CLK_SEL), .CH_ACK(CH_ACK)
    );

    always #5 C14M = ~C14M;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge C14M);
        #2;
    endtask

    // Model: a bus cycle starts on the edge the synchronised strobe is seen low;
    // local DTACK falls w+1 edges later, external cycles time out TIMEOUT edges later.
    logic [SYNC_STAGES-1:0] m_as_pipe, m_sw_pipe;
    logic       m_busy, m_local, m_term, m_dtack, m_berr, m_clk;
    logic [1:0] m_ack;
    int         m_t, m_w, m_ch;
    logic       as_now, sw_now, ext_now;

    // Behavioural model update on each rising edge
    always @(posedge C14M) begin
        if (RESET) begin
            m_as_pipe = {SYNC_STAGES{1'b1}};
            m_sw_pipe = {SYNC_STAGES{1'b1}};
            m_busy  = 1'b0;
            m_term  = 1'b0;
            m_dtack = 1'b1;
            m_berr  = 1'b1;
            m_clk   = 1'b1;
            m_ack   = 2'b00;
        end else begin
            as_now  = m_as_pipe[SYNC_STAGES-1];
            sw_now  = m_sw_pipe[SYNC_STAGES-1];
            ext_now = !DTACK_MB_n || !M6800_DTACK_n;
            if (!m_busy) begin
                if (!as_now) begin
                    m_busy  = 1'b1;
                    m_t     = 0;
                    m_term  = 1'b0;
                    m_local = (CH_SEL != 2'b00);
                    m_ch    = 0;
                    for (int i = NUM_CH - 1; i >= 0; i--) begin
                        if (CH_SEL[i]) m_ch = i;
                    end
                    m_w = int'(CH_WS[m_ch*WS_WIDTH +: WS_WIDTH]);
                end else if (DTACK_MB_n && M6800_DTACK_n) begin
                    m_clk = sw_now;
                end
            end else begin
                m_t++;
                if (m_local) begin
                    if (as_now) begin
                        m_busy  = 1'b0;
                        m_dtack = 1'b1;
                        m_ack   = 2'b00;
                    end else if (m_t == m_w + 1) begin
                        m_dtack      = 1'b0;
                        m_ack        = 2'b00;
                        m_ack[m_ch]  = 1'b1;
                    end
                end else if (!m_term) begin
                    if (ext_now) m_term = 1'b1;
                    else if (as_now) m_busy = 1'b0;
                    else if (m_t == TIMEOUT) begin
                        m_berr = 1'b0;
                        m_term = 1'b1;
                    end
                end else if (as_now) begin
                    m_busy = 1'b0;
                    m_berr = 1'b1;
                end
            end
            m_as_pipe = {m_as_pipe[SYNC_STAGES-2:0], AS_CPU_n};
            m_sw_pipe = {m_sw_pipe[SYNC_STAGES-2:0], SW1};
        end
    end

    // Per-cycle comparison of every output against the model
    always @(posedge C14M) begin
        #2;
        chk("cyc_DTACK_n", {7'd0, DTACK_n}, {7'd0, m_dtack & DTACK_MB_n & M6800_DTACK_n});
        chk("cyc_BERR_n",  {7'd0, BERR_n},  {7'd0, m_berr});
        chk("cyc_CLK_SEL", {7'd0, CLK_SEL}, {7'd0, m_clk});
        chk("cyc_CH_ACK",  {6'd0, CH_ACK},  {6'd0, m_ack});
    end

    initial begin
        tick(3);
        chk("rst_dtack", {7'd0, DTACK_n}, 8'd1);
        chk("rst_berr",  {7'd0, BERR_n},  8'd1);
        chk("rst_clk",   {7'd0, CLK_SEL}, 8'd1);
        chk("rst_chack", {6'd0, CH_ACK},  8'd0);
        @(negedge C14M); RESET = 1'b0;
        tick(4);

        // ch0, zero wait states
        @(negedge C14M); CH_SEL = 2'b01; CH_WS = 8'h00; AS_CPU_n = 1'b0;
        tick(3); chk("t1_early", {7'd0, DTACK_n}, 8'd1);
        tick(1); chk("t1_dtack", {7'd0, DTACK_n}, 8'd0);
        chk("t1_chack", {6'd0, CH_ACK}, 8'd1);
        @(negedge C14M); AS_CPU_n = 1'b1; CH_SEL = 2'b00;
        tick(2); chk("t1_hold", {7'd0, DTACK_n}, 8'd0);
        tick(1); chk("t1_release", {7'd0, DTACK_n}, 8'd1);
        chk("t1_chack_clr", {6'd0, CH_ACK}, 8'd0);
        tick(3);

        // both selected, ch0 (WS=3) wins; late decode changes ignored
        @(negedge C14M); CH_SEL = 2'b11; CH_WS = 8'h53; AS_CPU_n = 1'b0;
        tick(3);
        @(negedge C14M); CH_SEL = 2'b10; CH_WS = 8'h00;
        tick(3); chk("t2_early", {7'd0, DTACK_n}, 8'd1);
        tick(1); chk("t2_dtack", {7'd0, DTACK_n}, 8'd0);
        chk("t2_chack", {6'd0, CH_ACK}, 8'd1);
        @(negedge C14M); AS_CPU_n = 1'b1; CH_SEL = 2'b00;
        tick(5);

        // ch1 alone at the maximum wait-state count
        @(negedge C14M); CH_SEL = 2'b10; CH_WS = 8'hF0; AS_CPU_n = 1'b0;
        tick(18); chk("tmax_early", {7'd0, DTACK_n}, 8'd1);
        tick(1); chk("tmax_dtack", {7'd0, DTACK_n}, 8'd0);
        chk("tmax_chack", {6'd0, CH_ACK}, 8'd2);
        @(negedge C14M); AS_CPU_n = 1'b1; CH_SEL = 2'b00;
        tick(5);

        // external cycle terminated by the motherboard
        @(negedge C14M); AS_CPU_n = 1'b0;
        tick(10);
        @(negedge C14M); DTACK_MB_n = 1'b0;
        #1 chk("t3_follow", {7'd0, DTACK_n}, 8'd0);
        tick(2); chk("t3_noberr", {7'd0, BERR_n}, 8'd1);
        @(negedge C14M); DTACK_MB_n = 1'b1;
        #1 chk("t3_follow_hi", {7'd0, DTACK_n}, 8'd1);
        @(negedge C14M); AS_CPU_n = 1'b1;
        tick(5);

        // external cycle terminated by 6800 emulation
        @(negedge C14M); AS_CPU_n = 1'b0;
        tick(6);
        @(negedge C14M); M6800_DTACK_n = 1'b0;
        tick(1); chk("t3b_dtack", {7'd0, DTACK_n}, 8'd0);
        @(negedge C14M); AS_CPU_n = 1'b1; M6800_DTACK_n = 1'b1;
        tick(5);

        // unterminated external cycle -> BERR
        @(negedge C14M); AS_CPU_n = 1'b0;
        tick(257); chk("t4_before", {7'd0, BERR_n}, 8'd1);
        tick(1); chk("t4_berr", {7'd0, BERR_n}, 8'd0);
        chk("t4_nodtack", {7'd0, DTACK_n}, 8'd1);
        tick(20); chk("t4_held", {7'd0, BERR_n}, 8'd0);
        @(negedge C14M); AS_CPU_n = 1'b1;
        tick(2); chk("t4_still", {7'd0, BERR_n}, 8'd0);
        tick(1); chk("t4_clear", {7'd0, BERR_n}, 8'd1);
        tick(3);

        // external DTACK on the timeout edge wins
        @(negedge C14M); AS_CPU_n = 1'b0;
        tick(257);
        @(negedge C14M); DTACK_MB_n = 1'b0;
        tick(1); chk("t4b_noberr", {7'd0, BERR_n}, 8'd1);
        chk("t4b_dtack", {7'd0, DTACK_n}, 8'd0);
        tick(3); chk("t4b_noberr2", {7'd0, BERR_n}, 8'd1);
        @(negedge C14M); DTACK_MB_n = 1'b1; AS_CPU_n = 1'b1;
        tick(5);

        // speed switch requested mid-cycle
        @(negedge C14M); CH_SEL = 2'b01; CH_WS = 8'h07; AS_CPU_n = 1'b0;
        tick(5);
        @(negedge C14M); SW1 = 1'b0;
        tick(8); chk("t5_clk_hold", {7'd0, CLK_SEL}, 8'd1);
        chk("t5_dtack", {7'd0, DTACK_n}, 8'd0);
        @(negedge C14M); AS_CPU_n = 1'b1; CH_SEL = 2'b00;
        tick(3); chk("t5_clk_idle", {7'd0, CLK_SEL}, 8'd1);
        chk("t5_released", {7'd0, DTACK_n}, 8'd1);
        tick(1); chk("t5_clk_sw", {7'd0, CLK_SEL}, 8'd0);
        tick(2);

        // reset in the middle of a wait-state count
        @(negedge C14M); CH_SEL = 2'b01; AS_CPU_n = 1'b0;
        tick(5);
        @(negedge C14M); RESET = 1'b1;
        tick(1); chk("t5r_dtack", {7'd0, DTACK_n}, 8'd1);
        chk("t5r_clk", {7'd0, CLK_SEL}, 8'd1);
        chk("t5r_berr", {7'd0, BERR_n}, 8'd1);
        chk("t5r_chack", {6'd0, CH_ACK}, 8'd0);
        @(negedge C14M); RESET = 1'b0; AS_CPU_n = 1'b1; SW1 = 1'b1; CH_SEL = 2'b00;
        tick(6);

        // strobe withdrawn during wait states: no DTACK at all
        @(negedge C14M); CH_SEL = 2'b01; CH_WS = 8'h0A; AS_CPU_n = 1'b0;
        tick(7);
        @(negedge C14M); AS_CPU_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("t6_no_dtack", {7'd0, DTACK_n}, 8'd1);
        end
        chk("t6_chack", {6'd0, CH_ACK}, 8'd0);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
